// File: rtl/apb_i2c_regs.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// apb_i2c_regs
//
// APB3 slave register front-end for the I2C bridge. Holds the bridge control
// bytes and transmit word. Captures the receive word when a transfer ends.
// A small sequencer turns a software GO write into the bridge enable window.
// It also sets the sticky DONE / TIMEOUT flags that drive the interrupt.
//
// APB handshake: zero wait states, so PREADY is tied high. A write commits
// on the CLK edge where PSEL & PENABLE & PWRITE is high and PSLVERR is low.
// PRDATA and PSLVERR are combinational and are meaningful only while
// PSEL & PENABLE is high. Outside that window both are 0.
//
// Ports
//   CLK, rst_n          clock, asynchronous active-low reset
//   PSEL .. PSLVERR     APB3 slave interface (ADDR_W-bit byte address)
//   irq                 registered level interrupt
//   i2c_con1            {speed[1:0], rep, da, bytcnt[1:0], enable, srst}
//   i2c_con2            {rw, addr[6:0]}
//   i2c_din             transmit word to the bridge
//   i2c_dout            receive word from the bridge
//   i2c_stat            live bridge status byte
//   i2c_ready           bridge idle flag (1 = idle)
//
// Register map (byte addresses)
//   0x00 CTRL   [0] SRST [1] GO/busy [3:2] BYTCNT [4] DA [5] REP
//               [7:6] SPEED [8] IRQ_EN
//   0x04 ADDR   [7:0] {rw, addr[6:0]}
//   0x08 TXDATA
//   0x0C RXDATA (read-only)
//   0x10 STATUS [7:0] live stat, [8] BUSY, [9] DONE (W1C), [10] TIMEOUT (W1C)
// ---------------------------------------------------------------------------
module apb_i2c_regs #(
    parameter int ADDR_W    = 5,
    parameter int TO_W      = 20,
    parameter int TO_CYCLES = 1048575
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              irq,
    output logic [7:0]        i2c_con1,
    output logic [7:0]        i2c_con2,
    output logic [31:0]       i2c_din,
    input  logic [31:0]       i2c_dout,
    input  logic [7:0]        i2c_stat,
    input  logic              i2c_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_BUSY  = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'('h00);
    localparam logic [ADDR_W-1:0] A_ADDR   = ADDR_W'('h04);
    localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'('h08);
    localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'('h0C);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'('h10);

    // The last cycle allowed in a wait state. When this cycle is reached
    // without progress, the sequencer aborts.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] timer_q, timer_d;

    logic            srst_q, srst_d;
    logic [5:0]      cfg_q, cfg_d;          // {speed[1:0], rep, da, bytcnt[1:0]}
    logic            irq_en_q, irq_en_d;
    logic [7:0]      addr_q, addr_d;
    logic [31:0]     tx_q, tx_d;
    logic [31:0]     rx_q, rx_d;
    logic            done_q, done_d;
    logic            timeout_q, timeout_d;
    logic            irq_q, irq_d;

    logic            seq_enable, seq_done, seq_abort;
    logic            busy, timer_hit;
    logic            apb_acc, mapped, err;
    logic            sel_ctrl, sel_addr, sel_tx, sel_rx, sel_stat;
    logic            wr_ok, wr_ctrl, wr_addr, wr_tx, wr_stat;
    logic            srst_req, go_req;

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    assign apb_acc  = PSEL & PENABLE;
    assign sel_ctrl = (PADDR == A_CTRL);
    assign sel_addr = (PADDR == A_ADDR);
    assign sel_tx   = (PADDR == A_TXDATA);
    assign sel_rx   = (PADDR == A_RXDATA);
    assign sel_stat = (PADDR == A_STATUS);
    assign mapped   = sel_ctrl | sel_addr | sel_tx | sel_rx | sel_stat;
    assign busy     = (state_q != S_IDLE);

    // Config registers are frozen while a transfer is in flight. The only
    // exception is a CTRL write that carries SRST, which is how software
    // aborts a transfer.
    assign err = apb_acc & (~mapped
                          | (PWRITE & sel_rx)
                          | (PWRITE & busy & (sel_addr | sel_tx | (sel_ctrl & ~PWDATA[0]))));

    assign wr_ok   = apb_acc & PWRITE & ~err;
    assign wr_ctrl = wr_ok & sel_ctrl;
    assign wr_addr = wr_ok & sel_addr;
    assign wr_tx   = wr_ok & sel_tx;
    assign wr_stat = wr_ok & sel_stat;

    // SRST overrides GO in the same write.
    assign srst_req = wr_ctrl & PWDATA[0];
    assign go_req   = wr_ctrl & PWDATA[1] & ~PWDATA[0];

    assign PREADY  = 1'b1;
    assign PSLVERR = err;

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign timer_hit = (timer_q >= TO_LAST);

    // Sequencer: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go_req) state_d = S_ARM;
            S_ARM: begin
                if (!i2c_ready)     state_d = S_BUSY;
                else if (timer_hit) state_d = S_ABORT;
            end
            S_BUSY: begin
                if (i2c_ready)      state_d = S_DONE;
                else if (timer_hit) state_d = S_ABORT;
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (srst_req) state_d = S_IDLE;
    end

    // The timer counts the cycles spent in the current state. It restarts
    // on every transition and saturates at all-ones.
    always_comb begin
        if (state_d != state_q)  timer_d = '0;
        else if (timer_q != '1)  timer_d = timer_q + 1'b1;
        else                     timer_d = timer_q;
    end

    // Sequencer: outputs
    always_comb begin
        seq_enable = 1'b0;
        seq_done   = 1'b0;
        seq_abort  = 1'b0;
        case (state_q)
            S_ARM, S_BUSY: seq_enable = 1'b1;
            S_DONE:        seq_done   = 1'b1;
            S_ABORT:       seq_abort  = 1'b1;
            default:       ;
        endcase
    end

    // ------------------------------------------------------------------
    // Software registers and sticky flags
    // ------------------------------------------------------------------
    always_comb begin
        srst_d    = srst_q;
        cfg_d     = cfg_q;
        irq_en_d  = irq_en_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        done_d    = done_q;
        timeout_d = timeout_q;

        if (wr_ctrl) begin
            srst_d   = PWDATA[0];
            cfg_d    = PWDATA[7:2];
            irq_en_d = PWDATA[8];
        end
        if (wr_addr) addr_d = PWDATA[7:0];
        if (wr_tx)   tx_d   = PWDATA;
        if (wr_stat) begin
            if (PWDATA[9])  done_d    = 1'b0;
            if (PWDATA[10]) timeout_d = 1'b0;
        end
        // Setting a flag comes after its W1C clear, so a set in the same
        // cycle wins. An SRST write landing on the completion cycle
        // discards that completion.
        if (seq_done && !srst_req) begin
            rx_d   = i2c_dout;
            done_d = 1'b1;
        end
        if (seq_abort && !srst_req) timeout_d = 1'b1;
    end

    assign irq_d = irq_en_q & (done_q | timeout_q);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            srst_q    <= 1'b0;
            cfg_q     <= '0;
            irq_en_q  <= 1'b0;
            addr_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            srst_q    <= srst_d;
            cfg_q     <= cfg_d;
            irq_en_q  <= irq_en_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            irq_q     <= irq_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and bridge outputs
    // ------------------------------------------------------------------
    always_comb begin
        PRDATA = '0;
        if (apb_acc && !PWRITE) begin
            if (sel_ctrl)      PRDATA = {23'b0, irq_en_q, cfg_q, busy, srst_q};
            else if (sel_addr) PRDATA = {24'b0, addr_q};
            else if (sel_tx)   PRDATA = tx_q;
            else if (sel_rx)   PRDATA = rx_q;
            else if (sel_stat) PRDATA = {21'b0, timeout_q, done_q, busy, i2c_stat};
            else               PRDATA = '0;
        end
    end

    assign i2c_con1 = {cfg_q, seq_enable, srst_q};
    assign i2c_con2 = addr_q;
    assign i2c_din  = tx_q;
    assign irq      = irq_q;

endmodule
